// File: rtl/arc4_ctrl.sv
// ---------------------------------------------------------------------------
// arc4_ctrl -- top-level sequencer for an ARC4 engine.
//
// Runs the S-box init, key-scheduling (KSA) and keystream (PRGA) sub-blocks
// one after another. Each sub-block gets one start pulse, and the controller
// then waits for that block's ready flag to drop and rise again. Whichever
// block owns the current phase is the only one connected to the shared
// S-memory port.
//
// Optional feature: define ARC4_CTRL_CYCCNT_EN to add the cyc_cnt port and a
// saturating 16-bit run-length counter.
//
// Ports
//   clk, rst_n                      clock, async active-low reset
//   en, rdy                         start request / idle-and-ready
//   key, key_q                      cipher key in / key latched on accept
//   i_en, k_en, p_en                one-cycle starts to init / KSA / PRGA
//   i_rdy, k_rdy, p_rdy             sub-block ready flags
//   {i,k,p}_s_addr/_wrdata/_wren    per-block S-memory requests
//   s_addr, s_wrdata, s_wren        muxed S-memory port
//   cyc_cnt                         run length (ARC4_CTRL_CYCCNT_EN only)
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | rdy=1; waiting for en; S-memory port driven to zero
// ST_INIT | pulse i_en once i_rdy=1
// WT_INIT | wait for i_rdy to fall and then rise again
// ST_KSA  | pulse k_en once k_rdy=1
// WT_KSA  | wait for k_rdy to fall and then rise again
// ST_PRGA | pulse p_en once p_rdy=1
// WT_PRGA | wait for p_rdy to fall and then rise again; then return to IDLE
// ---------------------------------------------------------------------------
module arc4_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [23:0] key_q,
  output logic        i_en,
  output logic        k_en,
  output logic        p_en,
  input  logic        i_rdy,
  input  logic        k_rdy,
  input  logic        p_rdy,
  input  logic [7:0]  i_s_addr,
  input  logic [7:0]  k_s_addr,
  input  logic [7:0]  p_s_addr,
  input  logic [7:0]  i_s_wrdata,
  input  logic [7:0]  k_s_wrdata,
  input  logic [7:0]  p_s_wrdata,
  input  logic        i_s_wren,
  input  logic        k_s_wren,
  input  logic        p_s_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
`ifdef ARC4_CTRL_CYCCNT_EN
  ,
  output logic [15:0] cyc_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_INIT = 3'd1,
    WT_INIT = 3'd2,
    ST_KSA  = 3'd3,
    WT_KSA  = 3'd4,
    ST_PRGA = 3'd5,
    WT_PRGA = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_seen_busy;
  logic [23:0] r_key_q;
  logic        w_cur_rdy;
  logic        w_in_wait;
  logic        w_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Ready flag belonging to whichever sub-block owns the current phase.
  always_comb begin
    w_cur_rdy = 1'b1;
    w_in_wait = 1'b0;
    case (r_state)
      ST_INIT: w_cur_rdy = i_rdy;
      WT_INIT: begin w_cur_rdy = i_rdy; w_in_wait = 1'b1; end
      ST_KSA:  w_cur_rdy = k_rdy;
      WT_KSA:  begin w_cur_rdy = k_rdy; w_in_wait = 1'b1; end
      ST_PRGA: w_cur_rdy = p_rdy;
      WT_PRGA: begin w_cur_rdy = p_rdy; w_in_wait = 1'b1; end
      default: begin w_cur_rdy = 1'b1; w_in_wait = 1'b0; end
    endcase
    // A high ready flag alone is not enough to finish a phase: it must have
    // dropped first, or the start pulse's own ready cycle looks like done.
    w_done = w_in_wait & w_cur_rdy & r_seen_busy;
  end

  always_comb begin
    w_state_nxt = r_state;
    rdy         = 1'b0;
    i_en        = 1'b0;
    k_en        = 1'b0;
    p_en        = 1'b0;
    case (r_state)
      IDLE: begin
        rdy = 1'b1;
        if (en) w_state_nxt = ST_INIT;
      end
      ST_INIT: begin
        if (i_rdy) begin
          i_en        = 1'b1;
          w_state_nxt = WT_INIT;
        end
      end
      WT_INIT: if (w_done) w_state_nxt = ST_KSA;
      ST_KSA: begin
        if (k_rdy) begin
          k_en        = 1'b1;
          w_state_nxt = WT_KSA;
        end
      end
      WT_KSA: if (w_done) w_state_nxt = ST_PRGA;
      ST_PRGA: begin
        if (p_rdy) begin
          p_en        = 1'b1;
          w_state_nxt = WT_PRGA;
        end
      end
      WT_PRGA: if (w_done) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seen_busy <= 1'b0;
    end else if (w_in_wait && !w_done) begin
      if (!w_cur_rdy) r_seen_busy <= 1'b1;
    end else begin
      r_seen_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_q <= 24'h000000;
    end else if (r_state == IDLE && en) begin
      r_key_q <= key;
    end
  end

  assign key_q = r_key_q;

  // Only the phase owner reaches the S-memory port; IDLE drives zeros.
  always_comb begin
    s_addr   = 8'h00;
    s_wrdata = 8'h00;
    s_wren   = 1'b0;
    case (r_state)
      ST_INIT, WT_INIT: begin
        s_addr   = i_s_addr;
        s_wrdata = i_s_wrdata;
        s_wren   = i_s_wren;
      end
      ST_KSA, WT_KSA: begin
        s_addr   = k_s_addr;
        s_wrdata = k_s_wrdata;
        s_wren   = k_s_wren;
      end
      ST_PRGA, WT_PRGA: begin
        s_addr   = p_s_addr;
        s_wrdata = p_s_wrdata;
        s_wren   = p_s_wren;
      end
      default: begin
        s_addr   = 8'h00;
        s_wrdata = 8'h00;
        s_wren   = 1'b0;
      end
    endcase
  end

`ifdef ARC4_CTRL_CYCCNT_EN
  logic [15:0] r_cyc_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= 16'h0000;
    end else if (r_state == IDLE) begin
      if (en) r_cyc_cnt <= 16'h0000;
    end else if (r_cyc_cnt != 16'hFFFF) begin
      r_cyc_cnt <= r_cyc_cnt + 16'h0001;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
`endif

endmodule
